// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor counter table.
package bp_pkg;

  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
  localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                input logic             taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates {index, taken}.
module bp_upd_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == CNT_W'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// PC-indexed 2-bit counter table shared by fetch lookups and buffered EX updates.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int INDEX_W   = 6,
  parameter int UPD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  output logic            init_busy,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_ready,
  output logic            predict_valid,
  output logic            predict_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int FW      = INDEX_W + 1;
  localparam int CNT_W   = $clog2(UPD_DEPTH) + 1;

  state_t             r_state;
  logic [INDEX_W-1:0] r_init_idx;
  logic [CTR_W-1:0]   r_tbl [ENTRIES];
  logic               r_pred_valid;
  logic               r_pred_taken;

  logic               w_run;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic [FW-1:0]      w_fifo_dout;
  logic [INDEX_W-1:0] w_lk_idx;
  logic [INDEX_W-1:0] w_up_idx;
  logic [INDEX_W-1:0] w_dr_idx;
  logic               w_dr_taken;
  logic               w_lk_acc;
  logic               w_push;
  logic               w_drain;
  logic               w_unused;

  assign w_run        = (r_state == ST_RUN);
  assign w_lk_idx     = lookup_pc[INDEX_W+1:2];
  assign w_up_idx     = upd_pc[INDEX_W+1:2];
  assign w_dr_idx     = w_fifo_dout[FW-1:1];
  assign w_dr_taken   = w_fifo_dout[0];

  assign init_busy    = (r_state == ST_INIT);
  assign lookup_ready = w_run && !w_full;
  assign upd_ready    = w_run && !w_full;
  assign predict_valid = r_pred_valid;
  assign predict_taken = r_pred_taken;

  assign w_lk_acc = lookup_valid && lookup_ready;
  assign w_push   = upd_valid && upd_ready && !flush;
  // A full FIFO steals the port from fetch; otherwise drain only in idle lookup cycles.
  assign w_drain  = w_run && !w_empty && !flush && (w_full || !lookup_valid);

  bp_upd_fifo #(
    .W     (FW),
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (w_push),
    .din   ({w_up_idx, upd_taken}),
    .pop   (w_drain),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_init_idx   <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_acc && !flush;
      r_pred_taken <= w_lk_acc && !flush && r_tbl[w_lk_idx][1];
      if (flush) begin
        r_state    <= ST_INIT;
        r_init_idx <= '0;
      end else if (r_state == ST_INIT) begin
        r_init_idx <= r_init_idx + 1'b1;
        if (&r_init_idx) r_state <= ST_RUN;
      end
    end
  end

  // Storage is not reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)
      r_tbl[r_init_idx] <= CTR_SNT;
    else if (w_drain)
      r_tbl[w_dr_idx] <= ctr_next(r_tbl[w_dr_idx], w_dr_taken);
  end

  assign w_unused = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0],
                      upd_pc[PC_W-1:INDEX_W+2], upd_pc[1:0], w_fifo_cnt};

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench with a prediction scoreboard for bp_table_ctrl.
module tb_bp_table_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        init_busy;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_ready;
  logic        predict_valid;
  logic        predict_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;

  int errors = 0;
  int checks = 0;
  logic exp_q [$];
  int   tag_q [$];
  int   lk_tag = 0;

  bp_table_ctrl #(.PC_W(32), .INDEX_W(6), .UPD_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .init_busy     (init_busy),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_ready  (lookup_ready),
    .predict_valid (predict_valid),
    .predict_taken (predict_taken),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_ready     (upd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (predict_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_predict: got taken=%0b with no lookup outstanding", predict_taken);
        end else begin
          logic e;
          int   t;
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (predict_taken !== e) begin
            errors++;
            $display("FAIL predict_%0d: got taken=%0b expected %0b", t, predict_taken, e);
          end
        end
      end else if (predict_taken !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL taken_when_invalid: got %0b expected 0", predict_taken);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic exp);
    int n = 0;
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    while (!lookup_ready && n < 50) begin tick(); n++; end
    if (!lookup_ready) chk("lookup_timeout", 32'd1, 32'd0);
    else begin
      exp_q.push_back(exp);
      tag_q.push_back(lk_tag);
      lk_tag++;
    end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken);
    int n = 0;
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    while (!upd_ready && n < 50) begin tick(); n++; end
    if (!upd_ready) chk("upd_timeout", 32'd1, 32'd0);
    tick();
    upd_valid = 1'b0;
  endtask

  // Counts cycles of init_busy; readies must stay low throughout.
  task automatic wait_init(input string name);
    int   n = 0;
    logic rdy_seen = 1'b0;
    while (init_busy && n < 200) begin
      if (lookup_ready || upd_ready) rdy_seen = 1'b1;
      tick();
      n++;
    end
    chk({name, "_init_cycles"}, n, 64);
    chk({name, "_ready_in_init"}, {31'd0, rdy_seen}, 0);
    chk({name, "_ready_after"}, {30'd0, lookup_ready, upd_ready}, 32'd3);
  endtask

  initial begin
    logic [7:0] lr_log, ur_log;
    int         acc;

    #12;
    chk("rst_state", {27'd0, init_busy, lookup_ready, upd_ready, predict_valid, predict_taken},
        32'b10000);
    tick();
    rst = 1'b0;
    wait_init("boot");

    // Basic prediction on a fresh table, then train index 16.
    do_lookup(32'h40, 1'b0);
    do_upd(32'h40, 1'b1);
    do_upd(32'h40, 1'b1);
    idle(3);
    do_lookup(32'h40, 1'b1);
    do_upd(32'h40, 1'b1);
    do_upd(32'h40, 1'b0);
    do_upd(32'h40, 1'b0);
    idle(4);
    do_lookup(32'h40, 1'b0);

    // Saturation at 11 and aliasing through pc 0x108 (index 2).
    for (int i = 0; i < 5; i++) do_upd(32'h8, 1'b1);
    idle(6);
    do_lookup(32'h108, 1'b1);
    do_upd(32'h8, 1'b0);
    idle(3);
    do_lookup(32'h108, 1'b1);
    do_upd(32'h8, 1'b0);
    idle(3);
    do_lookup(32'h8, 1'b0);

    // FIFO-full priority with lookups held on index 0.
    acc = 0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h200;
    upd_pc       = 32'h4;
    upd_taken    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      upd_valid = (acc < 5);
      lr_log[k] = lookup_ready;
      ur_log[k] = upd_ready;
      if (upd_valid && upd_ready) acc++;
      if (lookup_ready) begin
        exp_q.push_back(1'b0);
        tag_q.push_back(lk_tag);
        lk_tag++;
      end
      tick();
    end
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    chk("full_upd_ready_seq", {24'd0, ur_log}, 32'b1010_1111);
    chk("full_lookup_ready_seq", {24'd0, lr_log}, 32'b1010_1111);
    chk("full_accepted", acc, 5);
    idle(6);
    do_lookup(32'h4, 1'b1);

    // Flush: trained entry and queued updates both vanish.
    do_upd(32'hC, 1'b1);
    do_upd(32'hC, 1'b1);
    idle(3);
    do_lookup(32'hC, 1'b1);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h200;
    upd_pc       = 32'hC;
    upd_taken    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1;
      if (lookup_ready) begin
        exp_q.push_back(1'b0);
        tag_q.push_back(lk_tag);
        lk_tag++;
      end
      tick();
    end
    upd_valid    = 1'b0;
    lookup_valid = 1'b0;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, init_busy}, 32'd1);
    wait_init("flush");
    idle(5);
    do_lookup(32'hC, 1'b0);

    // Async reset while a prediction is being presented in RUN.
    lookup_valid = 1'b1;
    lookup_pc    = 32'h4;
    tick();
    lookup_valid = 1'b0;
    chk("run_pv_before_rst", {31'd0, predict_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("run_async_rst", {28'd0, init_busy, lookup_ready, upd_ready, predict_valid}, 32'b1000);
    tick();
    tick();
    rst = 1'b0;
    wait_init("rst_run");

    // Async reset mid-INIT restarts the full sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(20);
    chk("midinit_busy", {31'd0, init_busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midinit_async_rst", {28'd0, init_busy, lookup_ready, upd_ready, predict_valid}, 32'b1000);
    tick();
    rst = 1'b0;
    wait_init("rst_init");
    do_lookup(32'h4, 1'b0);

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
